// File: rtl/dac_playback_streamer_if.sv
// FIFO read port and DAC sample output bundle of the playback streamer.
// The streamer is the master; the FIFO/DAC side is the slave.
interface dac_playback_streamer_if #(
    parameter int DATA_W  = 16,
    parameter int LEVEL_W = 11
);
    logic [2*DATA_W-1:0] fifo_dout;
    logic                fifo_empty;
    logic [LEVEL_W-1:0]  fifo_rd_count;
    logic                fifo_rd_en;
    logic [DATA_W-1:0]   dac_data_1;
    logic [DATA_W-1:0]   dac_data_2;
    logic                dac_valid;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_count,
        output fifo_rd_en,
        output dac_data_1,
        output dac_data_2,
        output dac_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_count,
        input  fifo_rd_en,
        input  dac_data_1,
        input  dac_data_2,
        input  dac_valid
    );
endinterface

// File: rtl/dac_playback_streamer.sv
// Host-to-DAC playback engine: waits for a FIFO prefill, then paces one 32-bit
// FIFO word per sample tick out as a byte-swapped DAC sample pair.
module dac_playback_streamer #(
    parameter int                DATA_W    = 16,
    parameter int                LEVEL_W   = 11,
    parameter int                PREFILL   = 256,
    parameter logic [DATA_W-1:0] IDLE_CODE = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [15:0]                sample_div,
    dac_playback_streamer_if.master    bus,
    output logic                       busy,
    output logic                       underflow,
    output logic [31:0]                sample_count
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PREFILL   = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_UNDERFLOW = 2'd3;

    localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

    logic [1:0]        state_q,     state_d;
    logic [15:0]       div_q,       div_d;
    logic [15:0]       div_cnt_q,   div_cnt_d;
    logic              rd_pend_q,   rd_pend_d;
    logic [DATA_W-1:0] data1_q,     data1_d;
    logic [DATA_W-1:0] data2_q,     data2_d;
    logic              valid_q,     valid_d;
    logic              underflow_q, underflow_d;
    logic [31:0]       count_q,     count_d;

    logic tick;
    logic rd_en;
    logic arm;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_cnt_d   = div_cnt_q;
        underflow_d = underflow_q;
        count_d     = count_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        valid_d     = 1'b0;

        tick  = (state_q == S_RUN) && (div_cnt_q == '0);
        // No read is launched when it would be discarded by stop or reset anyway.
        rd_en = tick && !bus.fifo_empty && !stop && !reset;
        arm   = start && !stop && ((state_q == S_IDLE) || (state_q == S_UNDERFLOW));

        rd_pend_d = rd_en;

        case (state_q)
            S_IDLE, S_UNDERFLOW: begin
                if (arm) begin
                    state_d     = S_PREFILL;
                    div_d       = (sample_div == '0) ? 16'd1 : sample_div;
                    underflow_d = 1'b0;
                    count_d     = '0;
                end
            end
            S_PREFILL: begin
                if (bus.fifo_rd_count >= PREFILL_LVL) begin
                    state_d   = S_RUN;
                    div_cnt_d = '0;
                end
            end
            S_RUN: begin
                div_cnt_d = (div_cnt_q == div_q - 16'd1) ? '0 : div_cnt_q + 16'd1;
                if (tick && bus.fifo_empty) begin
                    state_d     = S_UNDERFLOW;
                    underflow_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pending read still completes when RUN ends on underflow, so the last
        // pair is shown before the outputs fall back to the idle code.
        if (stop) begin
            state_d   = S_IDLE;
            rd_pend_d = 1'b0;
            data1_d   = IDLE_CODE;
            data2_d   = IDLE_CODE;
        end else if (rd_pend_q) begin
            data1_d = {bus.fifo_dout[7:0],   bus.fifo_dout[15:8]};
            data2_d = {bus.fifo_dout[23:16], bus.fifo_dout[31:24]};
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end else if (state_d != S_RUN) begin
            data1_d = IDLE_CODE;
            data2_d = IDLE_CODE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= 16'd1;
            div_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            data1_q     <= IDLE_CODE;
            data2_q     <= IDLE_CODE;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            rd_pend_q   <= rd_pend_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
            count_q     <= count_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.dac_data_1 = data1_q;
    assign bus.dac_data_2 = data2_q;
    assign bus.dac_valid  = valid_q;
    assign busy           = (state_q == S_PREFILL) || (state_q == S_RUN);
    assign underflow      = underflow_q;
    assign sample_count   = count_q;
endmodule

// File: tb/tb_dac_playback_streamer.sv
// Directed bench for dac_playback_streamer: a FIFO model feeds the DUT, and a
// monitor checks every presented pair against a queue of hand-computed pairs.
module tb_dac_playback_streamer;
    localparam logic [15:0] IDLE = 16'h8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] sample_div;
    logic        busy;
    logic        underflow;
    logic [31:0] sample_count;

    dac_playback_streamer_if #(.DATA_W(16), .LEVEL_W(11)) bus ();

    dac_playback_streamer #(
        .DATA_W   (16),
        .LEVEL_W  (11),
        .PREFILL  (4),
        .IDLE_CODE(IDLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .sample_div  (sample_div),
        .bus         (bus),
        .busy        (busy),
        .underflow   (underflow),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // FIFO model: standard mode, data valid the cycle after rd_en.
    logic [31:0] mem [0:63];
    logic [31:0] wr_ptr;
    logic [31:0] rd_ptr = '0;

    assign bus.fifo_empty    = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_count = 11'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr        <= rd_ptr + 32'd1;
        end
    end

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    task automatic expect_pair(input logic [15:0] d1, input logic [15:0] d2, input logic [31:0] cnt);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic pulse_start(input logic [15:0] div);
        sample_div = div;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.dac_valid), 32'd0);
        check({tag, "_d1"},    32'(bus.dac_data_1), 32'(IDLE));
        check({tag, "_d2"},    32'(bus.dac_data_2), 32'(IDLE));
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_pending_pairs"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; sample_div = '0; wr_ptr = '0;
        fork
            begin : stim
                tick(); tick();
                check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
                check("rst_underflow", 32'(underflow), 32'd0);
                check("rst_count", sample_count, 32'd0);
                check_idle_outputs("rst");
                reset = 1'b0;

                // 1: div=1, four words, sustained stream then underflow
                push(32'h01020304); expect_pair(16'h0403, 16'h0201, 32'd1);
                push(32'hDEADBEEF); expect_pair(16'hEFBE, 16'hADDE, 32'd2);
                push(32'h80000001); expect_pair(16'h0100, 16'h0080, 32'd3);
                push(32'hFFFF0000); expect_pair(16'h0000, 16'hFFFF, 32'd4);
                pulse_start(16'd1);
                check("t1_busy_prefill", 32'(busy), 32'd1);
                for (int t = 1; t <= 7; t++) begin
                    tick();
                    check("t1_valid", 32'(bus.dac_valid), 32'(t >= 3 && t <= 6));
                    check("t1_rd_en", 32'(bus.fifo_rd_en), 32'(t >= 1 && t <= 4));
                end
                check("t1_underflow", 32'(underflow), 32'd1);
                check("t1_count", sample_count, 32'd4);
                check_idle_outputs("t1_end");
                check_drained("t1");

                // 2: div=5 pacing and byte-swap
                push(32'h11223344); expect_pair(16'h4433, 16'h2211, 32'd1);
                push(32'hAABBCCDD); expect_pair(16'hDDCC, 16'hBBAA, 32'd2);
                push(32'h12345678); expect_pair(16'h7856, 16'h3412, 32'd3);
                push(32'hCAFEF00D); expect_pair(16'h0DF0, 16'hFECA, 32'd4);
                pulse_start(16'd5);
                check("t2_underflow_cleared", 32'(underflow), 32'd0);
                check("t2_count_cleared", sample_count, 32'd0);
                for (int t = 1; t <= 22; t++) begin
                    tick();
                    check("t2_valid", 32'(bus.dac_valid), 32'(t >= 3 && t <= 18 && (t - 3) % 5 == 0));
                    check("t2_rd_en", 32'(bus.fifo_rd_en), 32'(t <= 16 && t % 5 == 1));
                    if (t == 5) check("t2_hold_d1", 32'(bus.dac_data_1), 32'h4433);
                end
                check("t2_underflow", 32'(underflow), 32'd1);
                check("t2_count", sample_count, 32'd4);
                check_idle_outputs("t2_end");
                check_drained("t2");

                // 3: prefill threshold, one word short
                push(32'h00FF00FF); expect_pair(16'hFF00, 16'hFF00, 32'd1);
                push(32'h0A0B0C0D); expect_pair(16'h0D0C, 16'h0B0A, 32'd2);
                push(32'h55AA33CC); expect_pair(16'hCC33, 16'hAA55, 32'd3);
                pulse_start(16'd1);
                for (int t = 1; t <= 4; t++) begin
                    tick();
                    check("t3_busy", 32'(busy), 32'd1);
                    check("t3_no_rd", 32'(bus.fifo_rd_en), 32'd0);
                end
                push(32'h7F800001); expect_pair(16'h0100, 16'h807F, 32'd4);
                check("t3_rd_same_cycle", 32'(bus.fifo_rd_en), 32'd0);
                for (int t = 5; t <= 11; t++) begin
                    tick();
                    check("t3_rd_en", 32'(bus.fifo_rd_en), 32'(t <= 8));
                    check("t3_valid", 32'(bus.dac_valid), 32'(t >= 7 && t <= 10));
                end
                check("t3_underflow", 32'(underflow), 32'd1);
                stop = 1'b1; tick(); stop = 1'b0;
                check("t3_stop_keeps_underflow", 32'(underflow), 32'd1);
                check_drained("t3");

                // 4: stop with a read in flight
                push(32'h13579BDF); expect_pair(16'hDF9B, 16'h5713, 32'd1);
                push(32'h2468ACE0); push(32'h0F0F0F0F); push(32'h33333333);
                pulse_start(16'd5);
                check("t4_underflow_cleared", 32'(underflow), 32'd0);
                for (int t = 1; t <= 7; t++) begin
                    tick();
                    check("t4_rd_en", 32'(bus.fifo_rd_en), 32'(t == 1 || t == 6));
                    check("t4_valid", 32'(bus.dac_valid), 32'(t == 3));
                end
                stop = 1'b1; tick(); stop = 1'b0;
                check_idle_outputs("t4_stop");
                check("t4_underflow", 32'(underflow), 32'd0);
                check("t4_count", sample_count, 32'd1);
                tick();
                check("t4_discarded", 32'(bus.dac_valid), 32'd0);
                check("t4_count_hold", sample_count, 32'd1);
                flush();
                check_drained("t4");

                // 5: start+stop together, then start during RUN
                start = 1'b1; stop = 1'b1; sample_div = 16'd3;
                tick();
                start = 1'b0; stop = 1'b0;
                check("t5_stop_wins", 32'(busy), 32'd0);
                tick();
                check("t5_still_idle", 32'(busy), 32'd0);
                push(32'h0F1E2D3C); expect_pair(16'h3C2D, 16'h1E0F, 32'd1);
                push(32'h4B5A6978); expect_pair(16'h7869, 16'h5A4B, 32'd2);
                push(32'h99999999); push(32'h77777777);
                pulse_start(16'd5);
                repeat (4) tick();
                check("t5_count_before", sample_count, 32'd1);
                pulse_start(16'd2);
                check("t5_count_kept", sample_count, 32'd1);
                check("t5_busy", 32'(busy), 32'd1);
                for (int t = 6; t <= 10; t++) begin
                    tick();
                    check("t5_valid", 32'(bus.dac_valid), 32'(t == 8));
                end
                stop = 1'b1; tick(); stop = 1'b0;
                check("t5_count_end", sample_count, 32'd2);
                check_idle_outputs("t5_stop");
                flush();
                check_drained("t5");

                // 6: reset mid-RUN with div=0, then rerun with div=0
                push(32'h00010002); expect_pair(16'h0200, 16'h0100, 32'd1);
                push(32'h44444444); push(32'h55555555); push(32'h66666666);
                pulse_start(16'd0);
                repeat (3) tick();
                check("t6_valid_before_reset", 32'(bus.dac_valid), 32'd1);
                reset = 1'b1; tick(); reset = 1'b0;
                check("t6_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
                check("t6_rst_underflow", 32'(underflow), 32'd0);
                check("t6_rst_count", sample_count, 32'd0);
                check_idle_outputs("t6_rst");
                flush();
                push(32'h11223344); expect_pair(16'h4433, 16'h2211, 32'd1);
                push(32'hAABBCCDD); expect_pair(16'hDDCC, 16'hBBAA, 32'd2);
                push(32'h01020304); expect_pair(16'h0403, 16'h0201, 32'd3);
                push(32'hDEADBEEF); expect_pair(16'hEFBE, 16'hADDE, 32'd4);
                pulse_start(16'd0);
                for (int t = 1; t <= 7; t++) begin
                    tick();
                    check("t6_valid", 32'(bus.dac_valid), 32'(t >= 3 && t <= 6));
                    check("t6_rd_en", 32'(bus.fifo_rd_en), 32'(t >= 1 && t <= 4));
                end
                check("t6_underflow", 32'(underflow), 32'd1);
                check("t6_count", sample_count, 32'd4);
                check_drained("t6");
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (bus.dac_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_valid: got pair %h/%h expected no pair (t=%0t)",
                                     bus.dac_data_1, bus.dac_data_2, $time);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("pair_d1", 32'(bus.dac_data_1), 32'(e.d1));
                            check("pair_d2", 32'(bus.dac_data_2), 32'(e.d2));
                            check("pair_count", sample_count, e.cnt);
                        end
                    end
                end
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
